// File: rtl/fir_da_lut_loader.sv
// fir_da_lut_loader
// Builds the distributed-arithmetic partial-sum LUT for fir_filter.
// Taps arrive as a valid/ready stream, eight at a time (one group). For each
// group the loader emits all 256 partial sums, where entry n is the sum of
// the taps selected by the set bits of n. Writes go out on CIN/CADDR/CLOAD.
// When every group has been written, filt_en is raised so the filter may
// start taking samples.

module fir_da_lut_loader #(
    parameter int NGROUPS = 8,   // number of 8-tap groups
    parameter int COEF_W  = 16,  // signed tap width
    parameter int CIN_W   = 20,  // signed LUT entry width
    parameter int CADDR_W = 11   // LUT address width, log2(256*NGROUPS)
) (
    input  logic                      clk_fast,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [COEF_W-1:0]  coef_in,
    input  logic                      coef_valid,
    output logic                      coef_ready,
    output logic signed [CIN_W-1:0]   CIN,
    output logic [CADDR_W-1:0]        CADDR,
    output logic                      CLOAD,
    output logic                      busy,
    output logic                      filt_en
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int TAPS_PER_GROUP = 8;
    localparam int ENTRIES        = 256;
    localparam int GRP_W          = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int EXT_W          = CIN_W - COEF_W;

    localparam logic [GRP_W-1:0] LAST_GROUP = GRP_W'(NGROUPS - 1);
    localparam logic [7:0]       LAST_ENTRY = 8'(ENTRIES - 1);
    localparam logic [2:0]       LAST_TAP   = 3'(TAPS_PER_GROUP - 1);

    // FSM encoding
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]               state_q,   state_d;
    logic [GRP_W-1:0]         group_q,   group_d;
    logic [2:0]               tap_idx_q, tap_idx_d;
    logic [7:0]               entry_q,   entry_d;
    logic signed [CIN_W-1:0]  cin_q,     cin_d;
    logic [CADDR_W-1:0]       caddr_q,   caddr_d;
    logic                     cload_q,   cload_d;
    logic                     busy_q,    busy_d;
    logic                     filt_en_q, filt_en_d;

    // Tap registers of the group currently being processed
    logic signed [COEF_W-1:0] tap_q      [TAPS_PER_GROUP];
    logic [TAPS_PER_GROUP-1:0] tap_we;

    // Per-tap contribution to the current entry and their total
    logic signed [CIN_W-1:0]  tap_term   [TAPS_PER_GROUP];
    logic signed [CIN_W-1:0]  lut_sum;

    logic                     in_collect;
    logic                     coef_xfer;
    logic                     last_tap_xfer;
    logic                     last_entry;
    logic                     last_group;
    logic [CADDR_W-1:0]       entry_addr;

    // ------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------
    assign in_collect    = (state_q == S_COLLECT);
    assign coef_xfer     = in_collect && coef_valid;
    assign last_tap_xfer = coef_xfer && (tap_idx_q == LAST_TAP);
    assign last_entry    = (entry_q == LAST_ENTRY);
    assign last_group    = (group_q == LAST_GROUP);

    // Group index occupies the address bits above the 8-bit entry number
    assign entry_addr    = CADDR_W'({group_q, entry_q});

    // ------------------------------------------------------------------
    // Tap write enables and masked, sign-extended tap terms.
    // Bit b of the entry number selects tap b of the group.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < TAPS_PER_GROUP; gi++) begin : g_tap
            assign tap_we[gi]   = coef_xfer && (tap_idx_q == 3'(gi));
            assign tap_term[gi] = entry_q[gi]
                                ? {{EXT_W{tap_q[gi][COEF_W-1]}}, tap_q[gi]}
                                : '0;
        end
    endgenerate

    // Eight-input signed add at full CIN_W precision; cannot overflow since
    // |sum| <= 8 * 2^(COEF_W-1) and CIN_W >= COEF_W + 3.
    always_comb begin
        lut_sum = '0;
        for (int b = 0; b < TAPS_PER_GROUP; b++) begin
            lut_sum = lut_sum + tap_term[b];
        end
    end

    // Capture incoming taps into the slot addressed by the tap counter
    always_ff @(posedge clk_fast) begin
        if (reset) begin
            for (int b = 0; b < TAPS_PER_GROUP; b++) begin
                tap_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < TAPS_PER_GROUP; b++) begin
                if (tap_we[b]) begin
                    tap_q[b] <= coef_in;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic for the reload sequencer and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        group_d   = group_q;
        tap_idx_d = tap_idx_q;
        entry_d   = entry_q;
        cin_d     = cin_q;       // CIN/CADDR hold between write bursts
        caddr_d   = caddr_q;
        cload_d   = 1'b0;        // strobe is high only for issued entries
        busy_d    = busy_q;
        filt_en_d = filt_en_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    // The final entry has been written by now; release the filter
                    busy_d    = 1'b0;
                    filt_en_d = 1'b1;
                end
                if (start) begin
                    state_d   = S_COLLECT;
                    group_d   = '0;
                    tap_idx_d = '0;
                    entry_d   = '0;
                    busy_d    = 1'b1;
                    filt_en_d = 1'b0;
                end
            end

            S_COLLECT: begin
                // Gaps on coef_valid simply hold the counter; no timeout
                if (coef_xfer) begin
                    tap_idx_d = tap_idx_q + 3'd1;
                end
                if (last_tap_xfer) begin
                    state_d = S_WRITE;
                    entry_d = '0;
                end
            end

            S_WRITE: begin
                // One entry per cycle; outputs appear the cycle after issue
                cin_d   = lut_sum;
                caddr_d = entry_addr;
                cload_d = 1'b1;
                entry_d = entry_q + 8'd1;
                if (last_entry) begin
                    if (last_group) begin
                        state_d = S_DONE;
                    end else begin
                        group_d   = group_q + GRP_W'(1);
                        tap_idx_d = '0;
                        state_d   = S_COLLECT;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers with synchronous reset to the idle, all-zero state
    always_ff @(posedge clk_fast) begin
        if (reset) begin
            state_q   <= S_IDLE;
            group_q   <= '0;
            tap_idx_q <= '0;
            entry_q   <= '0;
            cin_q     <= '0;
            caddr_q   <= '0;
            cload_q   <= 1'b0;
            busy_q    <= 1'b0;
            filt_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            group_q   <= group_d;
            tap_idx_q <= tap_idx_d;
            entry_q   <= entry_d;
            cin_q     <= cin_d;
            caddr_q   <= caddr_d;
            cload_q   <= cload_d;
            busy_q    <= busy_d;
            filt_en_q <= filt_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign coef_ready = in_collect;
    assign CIN        = cin_q;
    assign CADDR      = caddr_q;
    assign CLOAD      = cload_q;
    assign busy       = busy_q;
    assign filt_en    = filt_en_q;

endmodule
